// File: rtl/psk_rx_sequencer.sv
// Bring-up and supervision sequencer for the PSK Rx demodulator: reset hold,
// wide-loop acquisition, narrow-loop tracking, and a valid-strobe watchdog with bounded retries.
module psk_rx_sequencer #(
  parameter int RST_CYC     = 16,
  parameter int ACQ_SYMS    = 64,
  parameter int VLD_TIMEOUT = 256,
  parameter int ACQ_SHIFT   = 1,
  parameter int TRK_SHIFT   = 3,
  parameter int MAX_RETRY   = 3
) (
  input  logic       clk_16M384,
  input  logic       rst_16M384,
  input  logic       start,
  input  logic       stop,
  input  logic       cfg_bpsk,
  input  logic [3:0] cfg_mode,
  input  logic       rx_vld,
  output logic       rx_rst,
  output logic       is_bpsk,
  output logic [3:0] FEEDBACK_SHIFT,
  output logic [3:0] MODE_CTRL,
  output logic [2:0] state,
  output logic       locked,
  output logic       fail,
  output logic [3:0] retry_cnt
);

  localparam int RW = $clog2(RST_CYC + 1);
  localparam int SW = $clog2(ACQ_SYMS + 1);
  localparam int WW = $clog2(VLD_TIMEOUT + 1);

  localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYC - 1);
  localparam logic [SW-1:0] SYM_LAST  = SW'(ACQ_SYMS - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(VLD_TIMEOUT - 1);
  localparam logic [3:0]    MAX_R     = 4'(MAX_RETRY);
  localparam logic [3:0]    ACQ_GAIN  = 4'(ACQ_SHIFT);
  localparam logic [3:0]    TRK_GAIN  = 4'(TRK_SHIFT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_ACQ   = 3'd2,
    S_TRACK = 3'd3,
    S_FAIL  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [RW-1:0] rst_cnt_reg, rst_cnt_next;
  logic [SW-1:0] sym_cnt_reg, sym_cnt_next;
  logic [WW-1:0] wd_cnt_reg, wd_cnt_next;
  logic [3:0]    retry_reg, retry_next;
  logic          is_bpsk_reg, is_bpsk_next;
  logic [3:0]    mode_reg, mode_next;
  logic          rx_rst_reg, locked_reg, fail_reg;
  logic [3:0]    fb_shift_reg;
  logic          watching;
  logic          timeout;
  logic [3:0]    retry_inc;

  assign watching  = (state_reg == S_ACQ) || (state_reg == S_TRACK);
  assign timeout   = watching && !rx_vld && (wd_cnt_reg == WD_LAST);
  assign retry_inc = (retry_reg == 4'hf) ? 4'hf : retry_reg + 4'd1;

  always_comb begin
    state_next   = state_reg;
    rst_cnt_next = rst_cnt_reg;
    sym_cnt_next = sym_cnt_reg;
    retry_next   = retry_reg;
    is_bpsk_next = is_bpsk_reg;
    mode_next    = mode_reg;
    wd_cnt_next  = '0;
    if (watching) begin
      wd_cnt_next = rx_vld ? '0 : wd_cnt_reg + 1'b1;
    end

    if (stop) begin
      state_next   = S_IDLE;
      rst_cnt_next = '0;
      sym_cnt_next = '0;
    end else begin
      case (state_reg)
        S_IDLE, S_FAIL: begin
          if (start) begin
            is_bpsk_next = cfg_bpsk;
            mode_next    = cfg_mode;
            retry_next   = 4'd0;
            rst_cnt_next = '0;
            sym_cnt_next = '0;
            state_next   = S_RESET;
          end
        end
        S_RESET: begin
          if (rst_cnt_reg == RST_LAST) begin
            rst_cnt_next = '0;
            sym_cnt_next = '0;
            state_next   = S_ACQ;
          end else begin
            rst_cnt_next = rst_cnt_reg + 1'b1;
          end
        end
        S_ACQ, S_TRACK: begin
          if (timeout) begin
            retry_next   = retry_inc;
            sym_cnt_next = '0;
            rst_cnt_next = '0;
            state_next   = (retry_inc < MAX_R) ? S_RESET : S_FAIL;
          end else if (rx_vld && state_reg == S_ACQ) begin
            if (sym_cnt_reg == SYM_LAST) begin
              sym_cnt_next = '0;
              state_next   = S_TRACK;
            end else begin
              sym_cnt_next = sym_cnt_reg + 1'b1;
            end
          end
        end
        default: state_next = S_IDLE;
      endcase
    end

    // Watchdog restarts on every state entry.
    if (state_next != state_reg) begin
      wd_cnt_next = '0;
    end
  end

  // Rx-facing outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge clk_16M384) begin
    if (rst_16M384) begin
      state_reg    <= S_IDLE;
      rst_cnt_reg  <= '0;
      sym_cnt_reg  <= '0;
      wd_cnt_reg   <= '0;
      retry_reg    <= 4'd0;
      is_bpsk_reg  <= 1'b1;
      mode_reg     <= 4'd0;
      rx_rst_reg   <= 1'b1;
      locked_reg   <= 1'b0;
      fail_reg     <= 1'b0;
      fb_shift_reg <= ACQ_GAIN;
    end else begin
      state_reg    <= state_next;
      rst_cnt_reg  <= rst_cnt_next;
      sym_cnt_reg  <= sym_cnt_next;
      wd_cnt_reg   <= wd_cnt_next;
      retry_reg    <= retry_next;
      is_bpsk_reg  <= is_bpsk_next;
      mode_reg     <= mode_next;
      rx_rst_reg   <= (state_next != S_ACQ) && (state_next != S_TRACK);
      locked_reg   <= (state_next == S_TRACK);
      fail_reg     <= (state_next == S_FAIL);
      fb_shift_reg <= (state_next == S_TRACK) ? TRK_GAIN : ACQ_GAIN;
    end
  end

  assign state          = state_reg;
  assign rx_rst         = rx_rst_reg;
  assign is_bpsk        = is_bpsk_reg;
  assign FEEDBACK_SHIFT = fb_shift_reg;
  assign MODE_CTRL      = mode_reg;
  assign locked         = locked_reg;
  assign fail           = fail_reg;
  assign retry_cnt      = retry_reg;

endmodule

// File: tb/tb_psk_rx_sequencer.sv
// Bench for psk_rx_sequencer: scripted vector table for the bring-up scenarios,
// then randomized traffic checked every cycle against a count-based reference model.
module tb_psk_rx_sequencer;

  localparam int RST_CYC     = 16;
  localparam int ACQ_SYMS    = 64;
  localparam int VLD_TIMEOUT = 256;
  localparam int ACQ_SHIFT   = 1;
  localparam int TRK_SHIFT   = 3;
  localparam int MAX_RETRY   = 3;

  logic       clk_16M384 = 1'b0;
  logic       rst_16M384, start, stop, cfg_bpsk, rx_vld;
  logic [3:0] cfg_mode;
  logic       rx_rst, is_bpsk, locked, fail;
  logic [3:0] FEEDBACK_SHIFT, MODE_CTRL, retry_cnt;
  logic [2:0] state;

  always #5 clk_16M384 = ~clk_16M384;

  psk_rx_sequencer dut (
    .clk_16M384     (clk_16M384),
    .rst_16M384     (rst_16M384),
    .start          (start),
    .stop           (stop),
    .cfg_bpsk       (cfg_bpsk),
    .cfg_mode       (cfg_mode),
    .rx_vld         (rx_vld),
    .rx_rst         (rx_rst),
    .is_bpsk        (is_bpsk),
    .FEEDBACK_SHIFT (FEEDBACK_SHIFT),
    .MODE_CTRL      (MODE_CTRL),
    .state          (state),
    .locked         (locked),
    .fail           (fail),
    .retry_cnt      (retry_cnt)
  );

  // One record: inputs held for reps cycles (rx_vld only on the last of them),
  // the block repeated `blocks` times, then outputs compared.
  typedef struct {
    int rst, start, stop, bpsk, mode, vld, reps, blocks;
    int st, rrst, fs, lk, fl, rty, bp, md;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: phase numbered as the state output, plus plain counts.
  int m_phase, m_left, m_syms, m_quiet, m_retry, m_bpsk, m_mode;

  task automatic add(input int rst, st_in, sp, b, m, v, reps, blocks,
                     input int st, rrst, fs, lk, fl, rty, bp, md);
    vec_t x;
    x = '{rst, st_in, sp, b, m, v, reps, blocks, st, rrst, fs, lk, fl, rty, bp, md};
    vecs.push_back(x);
  endtask

  task automatic check(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input int st, rrst, fs, lk, fl, rty, bp, md);
    check({tag, ".state"},          32'(state),          st);
    check({tag, ".rx_rst"},         32'(rx_rst),         rrst);
    check({tag, ".FEEDBACK_SHIFT"}, 32'(FEEDBACK_SHIFT), fs);
    check({tag, ".locked"},         32'(locked),         lk);
    check({tag, ".fail"},           32'(fail),           fl);
    check({tag, ".retry_cnt"},      32'(retry_cnt),      rty);
    check({tag, ".is_bpsk"},        32'(is_bpsk),        bp);
    check({tag, ".MODE_CTRL"},      32'(MODE_CTRL),      md);
  endtask

  task automatic cyc(input int r, s, p, b, m, v);
    rst_16M384 = (r != 0);
    start      = (s != 0);
    stop       = (p != 0);
    cfg_bpsk   = (b != 0);
    cfg_mode   = 4'(m);
    rx_vld     = (v != 0);
    @(posedge clk_16M384);
    #1;
  endtask

  task automatic model_step(input int r, s, p, b, m, v);
    if (r != 0) begin
      m_phase = 0; m_left = 0; m_syms = 0; m_quiet = 0;
      m_retry = 0; m_bpsk = 1; m_mode = 0;
    end else if (p != 0) begin
      m_phase = 0; m_left = 0; m_syms = 0; m_quiet = 0;
    end else if (s != 0 && (m_phase == 0 || m_phase == 4)) begin
      m_bpsk = b; m_mode = m; m_retry = 0; m_syms = 0;
      m_phase = 1; m_left = RST_CYC;
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        m_phase = 2; m_quiet = 0; m_syms = 0;
      end
    end else if (m_phase == 2 || m_phase == 3) begin
      if (v != 0) begin
        m_quiet = 0;
        if (m_phase == 2) begin
          m_syms++;
          if (m_syms == ACQ_SYMS) begin
            m_phase = 3; m_syms = 0;
          end
        end
      end else begin
        m_quiet++;
        if (m_quiet == VLD_TIMEOUT) begin
          m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          m_syms  = 0;
          m_quiet = 0;
          m_phase = (m_retry < MAX_RETRY) ? 1 : 4;
          m_left  = RST_CYC;
        end
      end
    end
  endtask

  initial begin
    int den;
    int r, s, p, b, m, v;

    //  rst st sp b  md v  reps blk | st rr fs lk fl rty bp md
    add(1, 0, 0, 0, 0, 0,   1,  1,   0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   2,  1,   0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,   1,  1,   1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,  15,  1,   1, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   1,  1,   2, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,  16, 63,   2, 0, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,  16,  1,   3, 0, 3, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 5, 0,   1,  1,   3, 0, 3, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 254,  1,   3, 0, 3, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1,  1,   3, 0, 3, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 255,  1,   3, 0, 3, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   1,  1,   1, 1, 1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,  15,  1,   1, 1, 1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   1,  1,   2, 0, 1, 0, 0, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1,  16, 64,   3, 0, 3, 1, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0, 0,   1,  1,   0, 1, 1, 0, 0, 1, 1, 0);
    add(0, 1, 1, 0, 5, 0,   1,  1,   0, 1, 1, 0, 0, 1, 1, 0);
    add(0, 1, 0, 0, 5, 0,   1,  1,   1, 1, 1, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0,  16,  1,   2, 0, 1, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 255,  1,   2, 0, 1, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0,   1,  1,   1, 1, 1, 0, 0, 1, 0, 5);
    add(0, 0, 0, 0, 0, 0,  16,  1,   2, 0, 1, 0, 0, 1, 0, 5);
    add(0, 0, 0, 0, 0, 0, 256,  1,   1, 1, 1, 0, 0, 2, 0, 5);
    add(0, 0, 0, 0, 0, 0,  16,  1,   2, 0, 1, 0, 0, 2, 0, 5);
    add(0, 0, 0, 0, 0, 0, 255,  1,   2, 0, 1, 0, 0, 2, 0, 5);
    add(0, 0, 0, 0, 0, 0,   1,  1,   4, 1, 1, 0, 1, 3, 0, 5);
    add(0, 0, 0, 0, 0, 1,   5,  1,   4, 1, 1, 0, 1, 3, 0, 5);
    add(0, 1, 0, 1,10, 0,   1,  1,   1, 1, 1, 0, 0, 0, 1, 10);
    add(0, 0, 0, 0, 0, 0,  16,  1,   2, 0, 1, 0, 0, 0, 1, 10);
    add(0, 0, 0, 0, 0, 1,   3,  1,   2, 0, 1, 0, 0, 0, 1, 10);
    add(1, 0, 0, 0, 0, 0,   1,  1,   0, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   2,  1,   0, 1, 1, 0, 0, 0, 1, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      for (int bk = 0; bk < vecs[i].blocks; bk++) begin
        for (int k = 0; k < vecs[i].reps; k++) begin
          cyc(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].bpsk, vecs[i].mode,
              (vecs[i].vld != 0 && k == vecs[i].reps - 1) ? 1 : 0);
        end
      end
      $display("vec %0d: state=%0d rx_rst=%0d shift=%0d locked=%0d fail=%0d retry=%0d bpsk=%0d mode=%0d",
               i, state, rx_rst, FEEDBACK_SHIFT, locked, fail, retry_cnt, is_bpsk, MODE_CTRL);
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].rrst, vecs[i].fs, vecs[i].lk,
                 vecs[i].fl, vecs[i].rty, vecs[i].bp, vecs[i].md);
    end

    // Randomized traffic: each 256-cycle segment picks a symbol-rate regime,
    // including sparse strobes that land near the watchdog boundary.
    model_step(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    den = 2;
    for (int i = 0; i < 8000; i++) begin
      if (i % 256 == 0) begin
        case ($urandom_range(0, 3))
          0: den = 2;
          1: den = 16;
          2: den = 250;
          default: den = 0;
        endcase
        $display("rnd seg %0d: vld_den=%0d state=%0d retry=%0d", i / 256, den, state, retry_cnt);
      end
      r = ($urandom_range(0, 2999) == 0) ? 1 : 0;
      p = ($urandom_range(0, 599) == 0) ? 1 : 0;
      s = ($urandom_range(0, 79) == 0) ? 1 : 0;
      b = int'($urandom_range(0, 1));
      m = int'($urandom_range(0, 15));
      v = (den != 0 && $urandom_range(0, den - 1) == 0) ? 1 : 0;
      model_step(r, s, p, b, m, v);
      cyc(r, s, p, b, m, v);
      check_outs($sformatf("rnd%0d", i), m_phase,
                 (m_phase == 2 || m_phase == 3) ? 0 : 1,
                 (m_phase == 3) ? TRK_SHIFT : ACQ_SHIFT,
                 (m_phase == 3) ? 1 : 0,
                 (m_phase == 4) ? 1 : 0,
                 m_retry, m_bpsk, m_mode);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psk_rx_sequencer.md
Name: psk_rx_sequencer

Overview:
Control FSM that brings up and supervises the PSK receive chain (Rx demodulator) in the loopback/radio datapath. On start it latches the modulation configuration and holds the Rx in reset. It then releases the Rx with a wide carrier-loop gain for acquisition and gear-shifts to a narrow gain for tracking. A watchdog on the demodulator's valid strobe restarts acquisition on stall and declares failure after a bounded number of retries.

Parameters:
RST_CYC, 16, cycles rx_rst is held high in RESET (>=1)
ACQ_SYMS, 64, rx_vld pulses counted in ACQ before switching to TRACK (>=1)
VLD_TIMEOUT, 256, max cycles between rx_vld pulses in ACQ/TRACK (>=2)
ACQ_SHIFT, 1, FEEDBACK_SHIFT value during ACQ (wide loop)
TRK_SHIFT, 3, FEEDBACK_SHIFT value during TRACK (narrow loop)
MAX_RETRY, 3, timeouts tolerated before FAIL (1..15)

Ports:
clk_16M384  in  1  system clock
rst_16M384  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin bring-up; honoured in IDLE and FAIL only
stop  in  1  single-cycle abort; any state -> IDLE
cfg_bpsk  in  1  1 = BPSK, 0 = QPSK; sampled on accepted start
cfg_mode  in  4  MODE_CTRL value; sampled on accepted start
rx_vld  in  1  demodulator symbol-valid strobe
rx_rst  out  1  reset to Rx chain, active high
is_bpsk  out  1  modulation select to Rx
FEEDBACK_SHIFT  out  4  carrier-loop gain shift to Rx
MODE_CTRL  out  4  Rx mode control
state  out  3  IDLE=0, RESET=1, ACQ=2, TRACK=3, FAIL=4
locked  out  1  high while in TRACK
fail  out  1  high while in FAIL
retry_cnt  out  4  timeouts since last accepted start

Behaviour:
- All outputs registered. Reset values: state=IDLE, rx_rst=1, is_bpsk=1, FEEDBACK_SHIFT=ACQ_SHIFT, MODE_CTRL=0, locked=0, fail=0, retry_cnt=0. All internal counters reset to 0.
- IDLE: rx_rst=1.
  - start=1 and stop=0: latch cfg_bpsk -> is_bpsk and cfg_mode -> MODE_CTRL, clear retry_cnt, go to RESET next cycle.
- RESET: rx_rst=1 for exactly RST_CYC cycles, FEEDBACK_SHIFT=ACQ_SHIFT. After those cycles go to ACQ; rx_rst falls on the first ACQ cycle.
- ACQ: rx_rst=0.
  - Count rx_vld pulses. The cycle that sees the ACQ_SYMS-th pulse transitions to TRACK.
  - In TRACK, FEEDBACK_SHIFT=TRK_SHIFT and locked=1 from the first TRACK cycle.
- TRACK: hold outputs. Remain until stop or timeout.
- Watchdog, active in ACQ/TRACK only:
  - Counter cleared on state entry and on every rx_vld cycle; otherwise it increments.
  - When the counter reaches VLD_TIMEOUT with no rx_vld, a timeout fires.
  - Timeout: retry_cnt+1 (saturating at 15), locked=0, symbol counter cleared.
  - If the new retry_cnt < MAX_RETRY, go to RESET (rx_rst=1 next cycle, FEEDBACK_SHIFT back to ACQ_SHIFT). Otherwise go to FAIL.
  - rx_vld in the timeout cycle cancels the timeout.
- FAIL: rx_rst=1, fail=1, retry_cnt held. start behaves as in IDLE (re-latches config, clears retry_cnt, goes to RESET).
- stop: in any state, next cycle state=IDLE, rx_rst=1, locked=0, fail=0. Latched config and retry_cnt are held.
- Priority within one cycle: stop > start > timeout > symbol-count progress.
  - start together with stop: stop wins, start is dropped.
  - start outside IDLE/FAIL: ignored.
  - cfg_* changes outside an accepted start: ignored.
- rx_vld in IDLE/RESET/FAIL: ignored, no counter changes.
- rst_16M384 mid-operation: synchronous return to all reset values on the next edge, regardless of state.

Test Plan:
- Defaults, start with cfg_bpsk=1, cfg_mode=4'b0000, rx_vld every 16 cycles -> rx_rst high exactly 16 cycles after start; state=ACQ with FEEDBACK_SHIFT=1; on the 64th rx_vld, next cycle state=3, locked=1, FEEDBACK_SHIFT=3, retry_cnt=0.
- Reach TRACK, then stop rx_vld -> 256 cycles after the last pulse: state=RESET, rx_rst=1, locked=0, retry_cnt=1, FEEDBACK_SHIFT=1. Resume rx_vld -> relocks after 64 symbols.
- rx_vld never asserted after start -> three timeouts, each followed by a 16-cycle RESET; after the third, state=4, fail=1, rx_rst=1, retry_cnt=3. A new start clears retry_cnt to 0 and enters RESET.
- In TRACK, pulse start with cfg_bpsk=0, cfg_mode=4'b0101 -> ignored, is_bpsk stays 1. Then stop, then start with the same cfg -> is_bpsk=0, MODE_CTRL=5, state=RESET.
- start and stop in the same IDLE cycle -> stays IDLE, rx_rst=1. rx_vld arriving exactly in the timeout cycle -> no timeout, retry_cnt unchanged.
- Assert rst_16M384 for one cycle during ACQ -> next cycle all outputs at reset values, state=0.
